uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sampler.sv | 63 ++++++
 rtl/uart_rx_param.sv | 130 +++++++++++++
 tb/tb_uart_rx_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding and the oversampling-ratio legality check.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK
  } rx_state_t;

  // Majority vote needs MID-1..MID+1 inside the bit with room to spare.
  function automatic bit cpb_legal(input int cpb);
    return (cpb >= 8) && ((cpb % 2) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: rx synchroniser, start-edge detect, per-bit
// phase counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rxs,
  output logic fall,
  output logic sample_strobe,
  output logic sample_bit
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  if (!cpb_legal(CLKS_PER_BIT)) begin : g_bad_cpb
    $error("uart_rx_sampler: CLKS_PER_BIT must be even and >= 8");
  end

  logic          sync1, rxs_prev, s_a, s_b;
  logic [CW-1:0] cnt;

  // Presetting to 1 keeps reset release from looking like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign fall = rxs_prev & ~rxs;

  always_ff @(posedge clk) begin
    if (rst || restart)                      cnt <= '0;
    else if (cnt == CW'(CLKS_PER_BIT - 1))   cnt <= '0;
    else                                     cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else begin
      if (cnt == CW'(MID - 1)) s_a <= rxs;
      if (cnt == CW'(MID))     s_b <= rxs;
    end
  end

  // Third sample is the live rxs at MID+1, where the decision is taken.
  assign sample_strobe = (cnt == CW'(MID + 1));
  assign sample_bit    = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, data shift register and a
// valid/ready output register with sticky overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t            state, state_nxt;
  logic                 rxs, fall, strobe, sbit, restart;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, perr, ferr, last_stop, stop_idx, last_slot;
  logic                 deliver, accept, load;

  assign restart = (state == IDLE) && fall;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .restart       (restart),
    .rxs           (rxs),
    .fall          (fall),
    .sample_strobe (strobe),
    .sample_bit    (sbit)
  );

  assign last_slot = (STOP_BITS == 1) || stop_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (strobe) state_nxt = sbit ? IDLE : DATA;
      DATA:    if (strobe && bit_idx == IW'(DATA_BITS - 1))
                 state_nxt = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
      PARITY:  if (strobe) state_nxt = STOP;
      STOP:    if (strobe && last_slot) state_nxt = DELIVER;
      // A low final stop bit means the line may be held in break.
      DELIVER: state_nxt = last_stop ? IDLE : BREAK;
      BREAK:   if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      last_stop <= 1'b1;
      stop_idx  <= 1'b0;
    end else if (strobe) begin
      case (state)
        START: begin
          bit_idx  <= '0;
          par_acc  <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
          stop_idx <= 1'b0;
        end
        DATA: begin
          shreg[bit_idx] <= sbit;
          par_acc        <= par_acc ^ sbit;
          bit_idx        <= bit_idx + IW'(1);
        end
        PARITY: perr <= (par_acc ^ sbit) ^ (PARITY_MODE == PARITY_ODD);
        STOP: begin
          if (!sbit) ferr <= 1'b1;
          last_stop <= sbit;
          stop_idx  <= stop_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign deliver = (state == DELIVER);
  assign accept  = data_valid & data_ready;
  assign load    = deliver & (~data_valid | data_ready);

  // Same-cycle accept and delivery replaces the word without an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (load) begin
        data_out   <= shreg;
        parity_err <= perr;
        frame_err  <= ferr;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
      if (deliver && !load) overrun_err <= 1'b1;
      else if (accept)      overrun_err <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8E1/16x, 8O1/16x, 7N2/8x)
// driven with table vectors, corner-case sequences and random frames.
module tb_uart_rx_param;

  localparam int CPB [3] = '{16, 16, 8};
  localparam int NB  [3] = '{8, 8, 7};
  localparam int PM  [3] = '{1, 2, 0};
  localparam int NS  [3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst;
  logic [2:0] rx, rdy;
  wire  [7:0] dout0, dout1;
  wire  [6:0] dout2;
  wire  [2:0] dv, pe, fe, ov, bsy;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .rx(rx[0]), .data_out(dout0), .data_valid(dv[0]),
    .data_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun_err(ov[0]), .busy(bsy[0]));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_o (
    .clk(clk), .rst(rst), .rx(rx[1]), .data_out(dout1), .data_valid(dv[1]),
    .data_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun_err(ov[1]), .busy(bsy[1]));

  uart_rx_param #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_n (
    .clk(clk), .rst(rst), .rx(rx[2]), .data_out(dout2), .data_valid(dv[2]),
    .data_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun_err(ov[2]), .busy(bsy[2]));

  typedef struct {
    int data;
    bit pe;
    bit fe;
  } word_t;

  typedef struct {
    int data;
    bit pbit;
    int stops;
    int xd;
    bit xpe;
    bit xfe;
  } vec_t;

  word_t cap [3][$];
  int    dvcyc [3] = '{0, 0, 0};
  int    ncmp = 0;
  int    nfail = 0;

  function automatic int get_dout(input int w);
    case (w)
      0:       return int'(dout0);
      1:       return int'(dout1);
      default: return int'(dout2);
    endcase
  endfunction

  // Record every handshake and count cycles that data_valid is high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i]) dvcyc[i] <= dvcyc[i] + 1;
      if (dv[i] && rdy[i]) cap[i].push_back('{get_dout(i), pe[i], fe[i]});
    end
  end

  // Reference: the word, parity and framing outcome derived from the frame rules.
  function automatic word_t model(input int w, input int data, input bit pbit, input int stops);
    word_t r;
    int m, sm;
    m      = (1 << NB[w]) - 1;
    sm     = (1 << NS[w]) - 1;
    r.data = data & m;
    if (PM[w] == 0) r.pe = 1'b0;
    else            r.pe = (^(data & m)) ^ pbit ^ (PM[w] == 2);
    r.fe   = ((stops & sm) != sm);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input bit v, input int n);
    rx[w] = v;
    repeat (n) @(negedge clk);
  endtask

  // Frame = start, data LSB first, optional parity, stop bits; spike inverts
  // the line for one cycle mid-way through frame bit index 'spike'.
  task automatic send_frame(input int w, input int data, input bit pbit,
                            input int stops, input int spike);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < NB[w]; i++) bits.push_back(data[i]);
    if (PM[w] != 0) bits.push_back(pbit);
    for (int i = 0; i < NS[w]; i++) bits.push_back(stops[i]);
    foreach (bits[k]) begin
      if (k == spike) begin
        drive(w, bits[k], CPB[w] / 2);
        drive(w, ~bits[k], 1);
        drive(w, bits[k], CPB[w] / 2 - 1);
      end else begin
        drive(w, bits[k], CPB[w]);
      end
    end
  endtask

  task automatic expect_one(input int w, input string nm, input word_t x);
    chk({nm, " count"}, cap[w].size(), 1);
    if (cap[w].size() > 0) begin
      chk({nm, " data"}, cap[w][0].data, x.data);
      chk({nm, " parity_err"}, int'(cap[w][0].pe), int'(x.pe));
      chk({nm, " frame_err"}, int'(cap[w][0].fe), int'(x.fe));
    end
    cap[w].delete();
  endtask

  vec_t  tbl [7];
  word_t exq [$];
  word_t x;

  initial begin
    rst = 1'b1;
    rx  = '1;
    rdy = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int w = 0; w < 3; w++) begin
      chk($sformatf("reset dv%0d", w), int'(dv[w]), 0);
      chk($sformatf("reset busy%0d", w), int'(bsy[w]), 0);
      chk($sformatf("reset ov%0d", w), int'(ov[w]), 0);
      chk($sformatf("reset dout%0d", w), get_dout(w), 0);
      chk($sformatf("reset pe/fe%0d", w), int'({pe[w], fe[w]}), 0);
    end

    // 8E1 table: data, parity bit sent, stop mask, expected word/flags.
    tbl[0] = '{'hA5, 1'b0, 1, 'hA5, 1'b0, 1'b0};
    tbl[1] = '{'h3C, 1'b1, 1, 'h3C, 1'b1, 1'b0};
    tbl[2] = '{'h00, 1'b0, 1, 'h00, 1'b0, 1'b0};
    tbl[3] = '{'hFF, 1'b1, 1, 'hFF, 1'b1, 1'b0};
    tbl[4] = '{'h80, 1'b1, 1, 'h80, 1'b0, 1'b0};
    tbl[5] = '{'h01, 1'b0, 1, 'h01, 1'b1, 1'b0};
    tbl[6] = '{'h7E, 1'b0, 0, 'h7E, 1'b0, 1'b1};
    foreach (tbl[i]) begin
      int c0;
      c0 = dvcyc[0];
      send_frame(0, tbl[i].data, tbl[i].pbit, tbl[i].stops, -1);
      drive(0, 1'b1, 32);
      expect_one(0, $sformatf("tbl[%0d]", i), '{tbl[i].xd, tbl[i].xpe, tbl[i].xfe});
      chk($sformatf("tbl[%0d] valid cycles", i), dvcyc[0] - c0, 1);
    end

    // Odd parity: 0x3C has four ones, so parity bit 1 is correct.
    send_frame(1, 'h3C, 1'b1, 1, -1);
    drive(1, 1'b1, 32);
    expect_one(1, "odd 3C/p1", '{'h3C, 1'b0, 1'b0});
    send_frame(1, 'h3C, 1'b0, 1, -1);
    drive(1, 1'b1, 32);
    expect_one(1, "odd 3C/p0", '{'h3C, 1'b1, 1'b0});

    // Short glitch is rejected as a false start.
    drive(0, 1'b0, 4);
    chk("glitch busy high", int'(bsy[0]), 1);
    drive(0, 1'b1, 16);
    chk("glitch busy low", int'(bsy[0]), 0);
    chk("glitch no word", cap[0].size(), 0);

    // One-cycle spike in data bit 3 is out-voted.
    send_frame(0, 'hFF, 1'b0, 1, 4);
    drive(0, 1'b1, 32);
    expect_one(0, "spike FF", '{'hFF, 1'b0, 1'b0});

    // Framing error followed by a held-low line.
    send_frame(0, 'h55, 1'b0, 0, -1);
    drive(0, 1'b0, 40 * 16);
    expect_one(0, "break 55", '{'h55, 1'b0, 1'b1});
    chk("break busy held", int'(bsy[0]), 1);
    drive(0, 1'b1, 32);
    chk("break released", int'(bsy[0]), 0);
    send_frame(0, 'h12, 1'b0, 1, -1);
    drive(0, 1'b1, 32);
    expect_one(0, "after break 12", '{'h12, 1'b0, 1'b0});

    // Overrun: consumer stalled across two back-to-back frames.
    rdy[0] = 1'b0;
    send_frame(0, 'h11, 1'b0, 1, -1);
    send_frame(0, 'h22, 1'b0, 1, -1);
    drive(0, 1'b1, 32);
    chk("overrun valid held", int'(dv[0]), 1);
    chk("overrun data kept", get_dout(0), 'h11);
    chk("overrun flag", int'(ov[0]), 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("overrun accept valid", int'(dv[0]), 0);
    chk("overrun accept clear", int'(ov[0]), 0);
    cap[0].delete();

    // 7N2: reset in the middle of data bit 4 aborts the frame.
    drive(2, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive(2, 1'(('h5A >> i) & 1), 8);
    drive(2, 1'(('h5A >> 4) & 1), 4);
    rst   = 1'b1;
    rx[2] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(2, 1'b1, 16);
    chk("abort no word", cap[2].size(), 0);
    chk("abort outputs", int'({dv[2], pe[2], fe[2], ov[2], bsy[2]}), 0);
    chk("abort dout", get_dout(2), 0);
    send_frame(2, 'h5A, 1'b0, 3, -1);
    drive(2, 1'b1, 16);
    expect_one(2, "7N2 5A", '{'h5A, 1'b0, 1'b0});

    // Random frames per configuration against the reference model.
    for (int w = 0; w < 3; w++) begin
      exq.delete();
      cap[w].delete();
      for (int n = 0; n < 15; n++) begin
        int d, st, gap;
        bit pb;
        d  = int'($urandom_range(0, 511));
        pb = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : 3;
        exq.push_back(model(w, d, pb, st));
        send_frame(w, d, pb, st, -1);
        if (model(w, d, pb, st).fe || $urandom_range(0, 2) != 0)
          gap = int'($urandom_range(CPB[w] / 2, 3 * CPB[w]));
        else
          gap = 0;
        if (gap > 0) drive(w, 1'b1, gap);
      end
      drive(w, 1'b1, 3 * CPB[w]);
      chk($sformatf("rand%0d count", w), cap[w].size(), exq.size());
      while (cap[w].size() > 0 && exq.size() > 0) begin
        word_t a;
        a = cap[w].pop_front();
        x = exq.pop_front();
        chk($sformatf("rand%0d data", w), a.data, x.data);
        chk($sformatf("rand%0d flags", w), int'({a.pe, a.fe}), int'({x.pe, x.fe}));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
